// File: rtl/skolem_chk_pkg.sv
// Shared definitions for the Skolem invertibility-condition checker.
//   - chk_state_e : checker FSM states
//   - W_DEF       : default operand width
//   - idx_width() : width of the {s,t} vector index for operand width w
//   - cnt_width() : width of the result counters, one bit wider than the index
//                   so a full run's worth of counts never wraps
package skolem_chk_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_SWEEP = 3'd2,
    ST_CHECK = 3'd3,
    ST_FIN   = 3'd4
  } chk_state_e;

  function automatic int idx_width(input int w);
    return 2 * w;
  endfunction

  function automatic int cnt_width(input int w);
    return (2 * w) + 1;
  endfunction

endpackage

// File: rtl/bv_lshr_sgt_eval.sv
// Combinational predicate P(a, k, t) = (a >> k) >s t.
// The shift is logical; a shift amount of W or more yields zero.
// Ports:
//   i_a   : value to shift
//   i_k   : shift amount
//   i_t   : signed comparison threshold
//   o_sat : 1 when the shifted value is signed-greater than i_t
module bv_lshr_sgt_eval #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_k,
  input  logic [W-1:0] i_t,
  output logic         o_sat
);

  // W fits in W+1 bits for any W >= 1, so the limit compare never truncates
  localparam logic [W:0] K_LIM = (W+1)'(W);

  logic [W-1:0] w_shift;

  // shift and signed compare
  always_comb begin
    w_shift = {W{1'b0}};
    if ({1'b0, i_k} >= K_LIM) begin
      w_shift = {W{1'b0}};
    end else begin
      w_shift = i_a >> i_k;
    end
    o_sat = $signed(w_shift) > $signed(i_t);
  end

endmodule

// File: rtl/skolem_inv_checker.sv
// Self-checking engine for W-bit Skolem witness circuits of (s >> x) >s t.
// Walks every {s,t} pair, lets an external function return a witness x_i,
// then sweeps all shift amounts to learn whether any witness exists and
// counts vectors where one exists but x_i is wrong.
// Configuration macro: SKOLEM_CHK_STOP_ON_FAIL_EN -- when defined, the run
// ends at the first failing vector.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a run (sampled in IDLE only)
//   s_o, t_o    : operands presented to the Skolem function
//   x_i         : candidate witness (combinational response to s_o/t_o)
//   busy        : run in progress
//   done        : one-cycle pulse when the run completes
//   pass        : 1 iff no failing vector (valid from done until next start)
//   fail_count  : vectors with a witness where x_i fails
//   sat_count   : vectors with a witness
//   first_fail  : {s,t} of the first failing vector, 0 if none
module skolem_inv_checker
  import skolem_chk_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [W-1:0] s_o,
  output logic [W-1:0] t_o,
  input  logic [W-1:0] x_i,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [2*W:0] fail_count,
  output logic [2*W:0] sat_count,
  output logic [2*W-1:0] first_fail
);

  localparam int IDX_W = idx_width(W);
  localparam int CNT_W = cnt_width(W);

  chk_state_e r_state;
  chk_state_e w_state_nxt;

  logic [IDX_W-1:0] r_v;
  logic [W-1:0]     r_k;
  logic [W-1:0]     r_cand;
  logic             r_exists;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] r_sat_cnt;
  logic [IDX_W-1:0] r_first_fail;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic w_cand_ok;
  logic w_sweep_sat;
  logic w_k_last;
  logic w_v_last;
  logic w_chk_fail;
  logic w_run_start;
  logic w_v_inc;
  logic w_busy_nxt;

  // operands come straight from the vector index, which only moves on DRIVE entry
  assign s_o        = r_v[IDX_W-1:W];
  assign t_o        = r_v[W-1:0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail_count = r_fail_cnt;
  assign sat_count  = r_sat_cnt;
  assign first_fail = r_first_fail;

  assign w_k_last   = (r_k == {W{1'b1}});
  assign w_v_last   = (r_v == {IDX_W{1'b1}});
  assign w_chk_fail = r_exists & ~w_cand_ok;

  bv_lshr_sgt_eval #(.W(W)) u_cand_eval (
    .i_a   (s_o),
    .i_k   (r_cand),
    .i_t   (t_o),
    .o_sat (w_cand_ok)
  );

  bv_lshr_sgt_eval #(.W(W)) u_sweep_eval (
    .i_a   (s_o),
    .i_k   (r_k),
    .i_t   (t_o),
    .o_sat (w_sweep_sat)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_run_start = 1'b0;
    w_v_inc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_DRIVE;
          w_run_start = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRIVE: w_state_nxt = ST_SWEEP;
      ST_SWEEP: begin
        if (w_k_last) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_state_nxt = ST_SWEEP;
        end
      end
      ST_CHECK: begin
`ifdef SKOLEM_CHK_STOP_ON_FAIL_EN
        if (w_chk_fail || w_v_last) begin
`else
        if (w_v_last) begin
`endif
          w_state_nxt = ST_FIN;
        end else begin
          w_state_nxt = ST_DRIVE;
          w_v_inc     = 1'b1;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SWEEP) ||
                 (w_state_nxt == ST_CHECK);
  end

  // vector index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= {IDX_W{1'b0}};
    end else if (w_run_start) begin
      r_v <= {IDX_W{1'b0}};
    end else if (w_v_inc) begin
      r_v <= r_v + IDX_W'(1);
    end
  end

  // candidate capture and shift-amount sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand   <= {W{1'b0}};
      r_k      <= {W{1'b0}};
      r_exists <= 1'b0;
    end else if (r_state == ST_DRIVE) begin
      r_cand   <= x_i;
      r_k      <= {W{1'b0}};
      r_exists <= 1'b0;
    end else if (r_state == ST_SWEEP) begin
      r_exists <= r_exists | w_sweep_sat;
      r_k      <= r_k + W'(1);
    end
  end

  // result counters and first failing vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_cnt   <= {CNT_W{1'b0}};
      r_sat_cnt    <= {CNT_W{1'b0}};
      r_first_fail <= {IDX_W{1'b0}};
    end else if (w_run_start) begin
      r_fail_cnt   <= {CNT_W{1'b0}};
      r_sat_cnt    <= {CNT_W{1'b0}};
      r_first_fail <= {IDX_W{1'b0}};
    end else if (r_state == ST_CHECK) begin
      if (r_exists) begin
        r_sat_cnt <= r_sat_cnt + CNT_W'(1);
      end
      if (w_chk_fail) begin
        r_fail_cnt <= r_fail_cnt + CNT_W'(1);
        // a zero count before this increment marks the first failure
        if (r_fail_cnt == {CNT_W{1'b0}}) begin
          r_first_fail <= r_v;
        end
      end
    end
  end

  // status outputs, registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= (w_state_nxt == ST_FIN);
      if (w_run_start) begin
        r_pass <= 1'b0;
      end else if (w_state_nxt == ST_FIN) begin
        // include the failure being counted in this same CHECK cycle
        r_pass <= (r_fail_cnt == {CNT_W{1'b0}}) & ~w_chk_fail;
      end
    end
  end

endmodule

// File: tb/tb_skolem_inv_checker.sv
// Bench for skolem_inv_checker (W=4) with a behavioural Skolem stub.
// Expected run results are queued when a run is launched and popped when
// the DUT signals done.
module tb_skolem_inv_checker;

  localparam int W = 4;
  localparam int FULL_DONE = 256 * 18 + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] s_o, t_o, x_i;
  logic         busy, done, pass;
  logic [2*W:0] fail_count, sat_count;
  logic [2*W-1:0] first_fail;

  int mode = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       pass;
    logic [8:0] fail;
    logic [8:0] sat;
    logic [7:0] ff;
    int         done_cyc;
  } res_t;

  res_t exp_q[$];
  res_t obs;
  res_t ex;
  int   obs_pulses, obs_busy_first, obs_busy_last, obs_busy_cnt;
  logic obs_busy_a1, obs_busy_a2;
  logic [3:0] obs_s1, obs_t1;

  always #5 clk = ~clk;

  skolem_inv_checker #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_o(s_o), .t_o(t_o), .x_i(x_i),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .sat_count(sat_count), .first_fail(first_fail)
  );

  // P(a,k,t) in integer arithmetic
  function automatic bit p_model(input logic [3:0] a, input int k, input logic [3:0] t);
    int r, tv;
    tv = (t >= 4'd8) ? int'(t) - 16 : int'(t);
    if (k >= 4) r = 0;
    else begin
      r = int'(a) / (1 << k);
      if (r >= 8) r = r - 16;
    end
    return r > tv;
  endfunction

  function automatic logic [3:0] golden_x(input logic [3:0] s, input logic [3:0] t);
    for (int k = 0; k < 16; k++) if (p_model(s, k, t)) return 4'(k);
    return 4'd0;
  endfunction

  function automatic logic [3:0] stub_x(input int m, input logic [3:0] s, input logic [3:0] t);
    if (m == 0) return golden_x(s, t);
    else if (m == 1) return 4'd0;
    else return 4'd15;
  endfunction

  assign x_i = stub_x(mode, s_o, t_o);

  function automatic res_t model(input int m, input int nvec);
    res_t r;
    logic [7:0] vv;
    logic [3:0] s, t;
    bit e, ok;
    r.pass = 1'b1; r.fail = 9'd0; r.sat = 9'd0; r.ff = 8'd0; r.done_cyc = FULL_DONE;
    for (int v = 0; v < nvec; v++) begin
      vv = 8'(v); s = vv[7:4]; t = vv[3:0]; e = 1'b0;
      for (int k = 0; k < 16; k++) if (p_model(s, k, t)) e = 1'b1;
      ok = p_model(s, int'(stub_x(m, s, t)), t);
      if (e) r.sat = r.sat + 9'd1;
      if (e && !ok) begin
        if (r.fail == 9'd0) r.ff = vv;
        r.fail = r.fail + 9'd1;
        r.pass = 1'b0;
`ifdef SKOLEM_CHK_STOP_ON_FAIL_EN
        r.done_cyc = (v + 1) * 18 + 1;
        break;
`endif
      end
    end
    return r;
  endfunction

  // Launch a run and record observations; cycle 1 is the cycle after the edge sampling start.
  task automatic run(input bit hold, input int abort_at);
    int  cyc;
    bit  seen;
    obs = '{pass: 1'b0, fail: 9'd0, sat: 9'd0, ff: 8'd0, done_cyc: -1};
    obs_pulses = 0; obs_busy_first = -1; obs_busy_last = -1; obs_busy_cnt = 0;
    obs_busy_a1 = 1'bx; obs_busy_a2 = 1'bx; obs_s1 = 4'hx; obs_t1 = 4'hx;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    cyc = 1; seen = 1'b0;
    while (cyc <= 6000) begin
      if (cyc == 1) begin obs_s1 = s_o; obs_t1 = t_o; end
      if (cyc == abort_at) break;
      if (busy === 1'b1 && !seen) begin
        if (obs_busy_first < 0) obs_busy_first = cyc;
        obs_busy_last = cyc;
        obs_busy_cnt++;
      end
      if (done === 1'b1) begin
        obs_pulses++;
        if (!seen) begin
          seen = 1'b1; obs.done_cyc = cyc; obs.pass = pass;
          obs.fail = fail_count; obs.sat = sat_count; obs.ff = first_fail;
        end
      end
      if (seen && cyc == obs.done_cyc + 1) obs_busy_a1 = busy;
      if (seen && cyc == obs.done_cyc + 2) begin obs_busy_a2 = busy; break; end
      @(posedge clk); #1; cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_vec++; if ({s_o, t_o} !== 8'h00) begin n_err++; $display("FAIL reset_st: got %h required 00", {s_o, t_o}); end
    n_vec++; if ({busy, done, pass} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b required 000", {busy, done, pass}); end
    n_vec++; if ({fail_count, sat_count, first_fail} !== 26'd0) begin n_err++; $display("FAIL reset_counts: got %h required 0", {fail_count, sat_count, first_fail}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_golden;
    mode = 0;
    exp_q.push_back('{pass: 1'b1, fail: 9'd0, sat: 9'd200, ff: 8'h00, done_cyc: FULL_DONE});
    run(1'b0, 0);
    ex = exp_q.pop_front();
    n_vec++; if (obs.done_cyc !== ex.done_cyc) begin n_err++; $display("FAIL golden_done_cyc: got %0d required %0d", obs.done_cyc, ex.done_cyc); end
    n_vec++; if (obs.pass !== ex.pass) begin n_err++; $display("FAIL golden_pass: got %b required %b", obs.pass, ex.pass); end
    n_vec++; if (obs.fail !== ex.fail) begin n_err++; $display("FAIL golden_fail: got %0d required %0d", obs.fail, ex.fail); end
    n_vec++; if (obs.sat !== ex.sat) begin n_err++; $display("FAIL golden_sat: got %0d required %0d", obs.sat, ex.sat); end
    n_vec++; if (obs.ff !== ex.ff) begin n_err++; $display("FAIL golden_ff: got %h required %h", obs.ff, ex.ff); end
    n_vec++; if (obs_busy_first !== 1 || obs_busy_last !== 4608 || obs_busy_cnt !== 4608) begin n_err++; $display("FAIL golden_busy: got %0d..%0d (%0d) required 1..4608 (4608)", obs_busy_first, obs_busy_last, obs_busy_cnt); end
    n_vec++; if (obs_pulses !== 1 || obs_busy_a1 !== 1'b0) begin n_err++; $display("FAIL golden_done_pulse: got pulses %0d busy_after %b required 1 0", obs_pulses, obs_busy_a1); end
    n_vec++; if ({obs_s1, obs_t1} !== 8'h00) begin n_err++; $display("FAIL golden_first_vec: got %h required 00", {obs_s1, obs_t1}); end
  endtask

  task automatic test_const_zero;
    mode = 1;
`ifdef SKOLEM_CHK_STOP_ON_FAIL_EN
    exp_q.push_back('{pass: 1'b0, fail: 9'd1, sat: model(1, 256).sat, ff: 8'h80, done_cyc: 2323});
`else
    exp_q.push_back('{pass: 1'b0, fail: 9'd80, sat: 9'd200, ff: 8'h80, done_cyc: FULL_DONE});
`endif
    run(1'b0, 0);
    ex = exp_q.pop_front();
    n_vec++; if (obs.done_cyc !== ex.done_cyc) begin n_err++; $display("FAIL x0_done_cyc: got %0d required %0d", obs.done_cyc, ex.done_cyc); end
    n_vec++; if (obs.pass !== ex.pass) begin n_err++; $display("FAIL x0_pass: got %b required %b", obs.pass, ex.pass); end
    n_vec++; if (obs.fail !== ex.fail) begin n_err++; $display("FAIL x0_fail: got %0d required %0d", obs.fail, ex.fail); end
    n_vec++; if (obs.sat !== ex.sat) begin n_err++; $display("FAIL x0_sat: got %0d required %0d", obs.sat, ex.sat); end
    n_vec++; if (obs.ff !== ex.ff) begin n_err++; $display("FAIL x0_ff: got %h required %h", obs.ff, ex.ff); end
  endtask

  task automatic test_const_max;
    mode = 2;
    exp_q.push_back(model(2, 256));
    run(1'b0, 0);
    ex = exp_q.pop_front();
    n_vec++; if (obs.done_cyc !== ex.done_cyc) begin n_err++; $display("FAIL x15_done_cyc: got %0d required %0d", obs.done_cyc, ex.done_cyc); end
    n_vec++; if (obs.pass !== ex.pass) begin n_err++; $display("FAIL x15_pass: got %b required %b", obs.pass, ex.pass); end
    n_vec++; if (obs.fail !== ex.fail) begin n_err++; $display("FAIL x15_fail: got %0d required %0d", obs.fail, ex.fail); end
    n_vec++; if (obs.sat !== ex.sat) begin n_err++; $display("FAIL x15_sat: got %0d required %0d", obs.sat, ex.sat); end
    n_vec++; if (obs.ff !== ex.ff) begin n_err++; $display("FAIL x15_ff: got %h required %h", obs.ff, ex.ff); end
  endtask

  task automatic test_reset_midrun;
    mode = 0;
    // at cycle 1000 vectors 0..54 have been checked
    exp_q.push_back(model(0, 55));
    run(1'b0, 1000);
    ex = exp_q.pop_front();
    n_vec++; if (sat_count !== ex.sat || busy !== 1'b1) begin n_err++; $display("FAIL midrun_sat: got %0d busy %b required %0d busy 1", sat_count, busy, ex.sat); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({s_o, t_o, busy, done, pass} !== 11'd0) begin n_err++; $display("FAIL async_rst_flags: got %h required 0", {s_o, t_o, busy, done, pass}); end
    n_vec++; if ({fail_count, sat_count, first_fail} !== 26'd0) begin n_err++; $display("FAIL async_rst_counts: got %h required 0", {fail_count, sat_count, first_fail}); end
    @(negedge clk); rst_n = 1'b1;
    exp_q.push_back('{pass: 1'b1, fail: 9'd0, sat: 9'd200, ff: 8'h00, done_cyc: FULL_DONE});
    run(1'b0, 0);
    ex = exp_q.pop_front();
    n_vec++; if (obs.done_cyc !== ex.done_cyc || obs.pass !== ex.pass) begin n_err++; $display("FAIL rerun_done: got cyc %0d pass %b required %0d %b", obs.done_cyc, obs.pass, ex.done_cyc, ex.pass); end
    n_vec++; if (obs.sat !== ex.sat || obs.fail !== ex.fail || obs.ff !== ex.ff) begin n_err++; $display("FAIL rerun_counts: got %0d %0d %h required %0d %0d %h", obs.sat, obs.fail, obs.ff, ex.sat, ex.fail, ex.ff); end
  endtask

  task automatic test_start_held;
    mode = 0;
    exp_q.push_back('{pass: 1'b1, fail: 9'd0, sat: 9'd200, ff: 8'h00, done_cyc: FULL_DONE});
    run(1'b1, 0);
    ex = exp_q.pop_front();
    n_vec++; if (obs.done_cyc !== ex.done_cyc || obs.sat !== ex.sat) begin n_err++; $display("FAIL held_done: got cyc %0d sat %0d required %0d %0d", obs.done_cyc, obs.sat, ex.done_cyc, ex.sat); end
    n_vec++; if (obs_pulses !== 1) begin n_err++; $display("FAIL held_pulses: got %0d required 1", obs_pulses); end
    n_vec++; if (obs_busy_a1 !== 1'b0 || obs_busy_a2 !== 1'b1) begin n_err++; $display("FAIL held_restart: got busy %b%b required 01", obs_busy_a1, obs_busy_a2); end
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_golden();
    test_const_zero();
    test_const_max();
    test_reset_midrun();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
